dio_status_collector: RTL
=========================

# dio_status_collector

Downstream consumer of the DIO test status stream. It periodically pulls the sticky per-pin mismatch flags from the DIO tester and accumulates them into 16 saturating error counters and a sample counter. On request, it snapshots and clears those counters and emits a fixed 9-word report packet on an AXI-stream toward the MicroBlaze.

## Interface
- PERIOD_WIDTH, 16, width of `sample_period`

- clk  in  1  system clock
- reset  in  1  reset, synchronous, active-high
- enable  in  1  1 = sampling active; 0 = interval counter held at 0, no samples
- sample_period  in  PERIOD_WIDTH  P; one sample every P+1 cycles (P=0 → every cycle)
- status_tdata  in  32  [15:0] sticky mismatch flags, [16] tester not running, [17] bad phase config, [31:18] ignored
- status_tvalid  in  1  status valid
- status_tready  out  1  pulse that consumes/clears the upstream sticky flags
- report_req  in  1  single-cycle request for a report
- report_busy  out  1  high from request acceptance until the last word is accepted
- report_tdata  out  32  report word
- report_tvalid  out  1  report word valid
- report_tready  in  1  downstream ready
- report_tlast  out  1  high on word 8

## Operation
Interval counter:
- `icnt` counts 0..P, then wraps to 0.
- Held at 0 while `enable`=0 or `reset`.
- Sample point: `enable` && `icnt`==P.

Sampling:
- `status_tready` = sample point && `status_tvalid` (combinational). At most one cycle per period.
- If `status_tvalid`=0 at the sample point, the sample is skipped and not counted. `icnt` still wraps.
- On each accepted sample:
  - `smp_cnt` (16-bit) increments, saturating at 0xFFFF.
  - For each j in 0..15 with `status_tdata[j]`=1, `err_cnt[j]` (16-bit) increments, saturating at 0xFFFF.
  - Sticky `nr_seen` |= `status_tdata[16]`.
  - Sticky `bp_seen` |= `status_tdata[17]`.
- Sampling continues unchanged while a report is in flight.

Report FSM: IDLE, SEND(idx 0..8).
- IDLE, `report_req`=1:
  - Copy `smp_cnt`, `err_cnt[0..15]`, `nr_seen`, `bp_seen` into snapshot registers.
  - Clear the live copies in the same cycle. If a sample is accepted that same cycle, live values become cleared+increment, i.e. 1 for counters and the flag value for `nr_seen`/`bp_seen`. No sample is lost or double-counted.
  - Go to SEND idx 0.
- `report_req` outside IDLE is ignored (no queueing).
- SEND: `report_tvalid`=1. On `report_tvalid` && `report_tready`, idx increments. After idx 8 is accepted → IDLE.
- Word formats:
  - Word 0: {8'hD1, 6'b0, bp_seen, nr_seen, smp_cnt}.
  - Word k (1..8): {err_cnt[2k-1], err_cnt[2k-2]} from the snapshot.
- `report_tlast`=1 only on idx 8.
- `report_busy`=1 in SEND.

Reset values:
- `status_tready`=0, `report_tvalid`=0, `report_tlast`=0, `report_busy`=0, `report_tdata`=0.
- All counters, flags and snapshots cleared; FSM in IDLE; `icnt`=0.

Reset mid-packet: abort immediately. `report_tvalid` is low the cycle after reset is sampled; no `tlast` is emitted for the partial packet.

## Timing
- `status_tready` is combinational from `icnt`, `enable` and `status_tvalid`. Counters reflect a sample at the following edge.
- First sample after `reset` deasserts with `enable`=1 is at cycle P (0-based).
- `report_req` sampled high in IDLE at edge t → `report_tvalid` and word 0 valid from t+1. `report_busy` is high from t+1.
- `report_tdata`/`report_tlast` are registered and held stable while `report_tvalid` && !`report_tready`.
- Minimum packet is 9 cycles.
- Accepting word 8 at edge u → IDLE at u+1 with `report_busy`=0. A `report_req` at u+1 is accepted.
- Changing `sample_period` takes effect at the next wrap. If the new P is below the current `icnt`, `icnt` continues to the width maximum and wraps; no special handling.

## Test plan
- Constant count: P=3, `enable`=1, `status_tdata`=0x0000_0005 held, run 40 cycles, then request a report.
  - `status_tready` pulses every 4th cycle.
  - Report: word0=0xD100_000A, word1=0x0000_000A, word2=0x0000_000A, words3-8=0, `tlast` on word 8.
- Backpressure: toggle `report_tready` 1/0 each cycle.
  - Each word is held stable until accepted; exactly 9 beats delivered.
  - `report_busy` falls the cycle after word 8 is accepted.
- Saturation: P=0, `status_tdata`=0x0000_8000 for 70000 cycles, then report.
  - word0=0xD100_FFFF, word8=0xFFFF_0000.
- Status flags: one sample with `status_tdata`=0x0003_0000.
  - Report word0=0xD103_0001, all error words 0.
  - A second report with no new samples gives word0=0xD100_0000.
- Simultaneous sample and request: `report_req` on a sample-point cycle with `status_tdata`=0x1.
  - The snapshot excludes that sample.
  - The next report shows word0=0xD100_0001, word1=0x0000_0001.
  - Also: `status_tvalid`=0 at a sample point → no `status_tready`, `smp_cnt` unchanged.
- Reset mid-packet: assert `reset` after word 3 is accepted.
  - `report_tvalid`=0 the next cycle; no `tlast` seen.
  - After reset, a report gives word0=0xD100_0000.

Source files
------------

// File: rtl/dio_status_collector.sv
`default_nettype none
// ============================================================================
// Module      : dio_status_collector
// Description : Pulls sticky per-pin mismatch flags from the DIO tester once
//               per sample interval and accumulates them into 16 saturating
//               error counters plus a sample counter. A report request
//               snapshots and clears the counters, then streams a 9-word
//               packet over AXI-stream.
// Revision    : 1.0 - initial release
// ============================================================================
module dio_status_collector #(
  parameter int PERIOD_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [PERIOD_WIDTH-1:0] sample_period,
  input  logic [31:0]             status_tdata,
  input  logic                    status_tvalid,
  output logic                    status_tready,
  input  logic                    report_req,
  output logic                    report_busy,
  output logic [31:0]             report_tdata,
  output logic                    report_tvalid,
  input  logic                    report_tready,
  output logic                    report_tlast
);

  localparam logic [3:0]              C_LAST_IDX = 4'd8;
  localparam logic [PERIOD_WIDTH-1:0] C_ICNT_ONE = {{(PERIOD_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [PERIOD_WIDTH-1:0] r_icnt;
  logic [15:0]             r_smp_cnt;
  logic [15:0]             r_err_cnt  [16];
  logic [15:0]             r_snap_err [16];
  logic                    r_nr_seen;
  logic                    r_bp_seen;
  logic [3:0]              r_idx;
  logic [31:0]             r_tdata;
  logic                    r_tlast;

  logic       w_sample;
  logic       w_take;
  logic       w_beat;
  logic       w_last_beat;
  logic [3:0] w_nidx;
  logic [3:0] w_lo_sel;
  logic [3:0] w_hi_sel;
  logic       w_unused;

  // Upper status bits carry no information for this block.
  assign w_unused = ^status_tdata[31:18];

  // A sample is taken only at the end of each interval and only if upstream
  // has status to offer; reset suppresses the handshake entirely.
  assign w_sample      = !reset && enable && (r_icnt == sample_period) && status_tvalid;
  assign status_tready = w_sample;

  assign w_take      = (r_state == S_IDLE) && report_req;
  assign w_beat      = (r_state == S_SEND) && report_tready;
  assign w_last_beat = w_beat && (r_idx == C_LAST_IDX);

  // Word k (1..8) packs error counters 2k-1 (high) and 2k-2 (low); the 4-bit
  // subtraction maps k=8 onto 14 through wrap-around.
  assign w_nidx   = r_idx + 4'd1;
  assign w_lo_sel = {w_nidx[2:0], 1'b0} - 4'd2;
  assign w_hi_sel = w_lo_sel | 4'd1;

  assign report_tvalid = (r_state == S_SEND);
  assign report_busy   = (r_state == S_SEND);
  assign report_tdata  = r_tdata;
  assign report_tlast  = r_tlast;

  // Interval counter: 0..P then wrap; a shrinking P simply lets it roll over.
  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      r_icnt <= '0;
    end else if (r_icnt == sample_period) begin
      r_icnt <= '0;
    end else begin
      r_icnt <= r_icnt + C_ICNT_ONE;
    end
  end

  // Live counters and snapshot; a take clears live state but folds in any
  // sample accepted on that same edge so nothing is lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_smp_cnt <= '0;
      r_nr_seen <= 1'b0;
      r_bp_seen <= 1'b0;
      for (int j = 0; j < 16; j++) begin
        r_err_cnt[j]  <= '0;
        r_snap_err[j] <= '0;
      end
    end else if (w_take) begin
      r_smp_cnt <= {15'd0, w_sample};
      r_nr_seen <= w_sample & status_tdata[16];
      r_bp_seen <= w_sample & status_tdata[17];
      for (int j = 0; j < 16; j++) begin
        r_snap_err[j] <= r_err_cnt[j];
        r_err_cnt[j]  <= {15'd0, w_sample & status_tdata[j]};
      end
    end else if (w_sample) begin
      if (r_smp_cnt != 16'hFFFF) begin
        r_smp_cnt <= r_smp_cnt + 16'd1;
      end
      r_nr_seen <= r_nr_seen | status_tdata[16];
      r_bp_seen <= r_bp_seen | status_tdata[17];
      for (int j = 0; j < 16; j++) begin
        if (status_tdata[j] && (r_err_cnt[j] != 16'hFFFF)) begin
          r_err_cnt[j] <= r_err_cnt[j] + 16'd1;
        end
      end
    end
  end

  // Report FSM state and word index registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_take) begin
        r_idx <= '0;
      end else if (w_beat) begin
        r_idx <= w_nidx;
      end
    end
  end

  // Report FSM next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (report_req) w_state_nxt = S_SEND;
      S_SEND:  if (w_last_beat) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Registered report word; word 0 is built from live values at take time
  // since they equal what the snapshot captures on that edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tdata <= '0;
      r_tlast <= 1'b0;
    end else if (w_take) begin
      r_tdata <= {8'hD1, 6'b0, r_bp_seen, r_nr_seen, r_smp_cnt};
      r_tlast <= 1'b0;
    end else if (w_last_beat) begin
      r_tdata <= '0;
      r_tlast <= 1'b0;
    end else if (w_beat) begin
      r_tdata <= {r_snap_err[w_hi_sel], r_snap_err[w_lo_sel]};
      r_tlast <= (w_nidx == C_LAST_IDX);
    end
  end

endmodule
`default_nettype wire
